triangle_monitor: RTL and testbench
===================================

TRIANGLE_MONITOR -- requirements
Module: triangle_monitor

Interface
REQ-001 SHALL have parameter WIDTH, default 4, giving the sample width; TOP = 2^WIDTH-1.
REQ-002 SHALL have port clock, input, 1, the single clock; all state updates on its rising edge.
REQ-003 SHALL have port reset, input, 1, synchronous active-high reset.
REQ-004 SHALL have port sample, input, WIDTH, the value driven by the up/down bounce counter.
REQ-005 SHALL have port sample_valid, input, 1; sample is consumed only on cycles where it is high.
REQ-006 SHALL have port locked, output, 1; high while tracking the sequence.
REQ-007 SHALL have port direction, output, 1; 0 = counting up, 1 = counting down. Same encoding as the generator.
REQ-008 SHALL have port peak, output, 1; one-cycle pulse.
REQ-009 SHALL have port valley, output, 1; one-cycle pulse.
REQ-010 SHALL have port mismatch, output, 1; one-cycle pulse.
REQ-011 SHALL have port err_count, output, 8; saturating mismatch count.
REQ-012 SHALL have port period, output, WIDTH+2; last measured valley-to-valley sample count.

Function
REQ-013 SHALL model the source sequence 0,1,..,TOP,TOP,TOP-1,..,0,0,1,..., so every endpoint value repeats exactly once and the period is 2^(WIDTH+1) samples.
REQ-014 SHALL use states ACQ0, ACQ1, UP, TOP_HOLD, DOWN and BOT_HOLD, with a registered prev sample.
REQ-015 On a valid sample, ACQ0 SHALL store prev and move to ACQ1.
REQ-016 On a valid sample s, ACQ1 SHALL move as follows; locked rises on the same edge as the state change:
- s==prev+1 (prev<TOP): go to UP.
- s==prev-1 (prev>0): go to DOWN.
- s==prev==TOP: go to DOWN.
- s==prev==0: go to UP.
- Any other s: stay in ACQ1 with prev<=s, without asserting mismatch.
REQ-017 In UP, the expected value SHALL be prev+1; on s==TOP, go to TOP_HOLD.
REQ-018 In TOP_HOLD, the expected value SHALL be TOP; on a match, pulse peak and go to DOWN.
REQ-019 In DOWN, the expected value SHALL be prev-1; on s==0, go to BOT_HOLD.
REQ-020 In BOT_HOLD, the expected value SHALL be 0; on a match, pulse valley and go to UP.
REQ-021 The direction output SHALL be registered:
- 0 in ACQ0, ACQ1, UP and BOT_HOLD.
- 1 in TOP_HOLD and DOWN.
REQ-022 A valid sample that differs from the expected value while locked SHALL cause, on the same edge:
- a mismatch pulse;
- err_count+1, saturating at 255;
- locked<=0 and a move to ACQ1 with prev<=s.
REQ-023 Pulses SHALL appear the cycle after the consuming edge and last exactly one cycle; when sample_valid is low, state, prev and counters SHALL hold and all pulses SHALL be 0.
REQ-024 All arithmetic SHALL be evaluated at WIDTH bits, with no wrap: prev+1 is never expected from TOP, and prev-1 is never expected from 0.

Reset
REQ-025 On reset, the block SHALL go to ACQ0 with every output 0: locked, direction, peak, valley, mismatch, err_count, period and prev.
REQ-026 Reset SHALL override sample_valid in the same cycle, and asserting it mid-sequence SHALL discard all lock state.

Configuration
REQ-027 Macro TRIANGLE_MONITOR_PERIOD_EN SHALL enable period measurement, and the period port SHALL exist in both builds.
REQ-028 With TRIANGLE_MONITOR_PERIOD_EN defined, the period measurement SHALL work as follows:
- A WIDTH+2 bit counter increments on each valid sample while locked.
- On each valley pulse after the first valley since lock, period<=counter value including the current sample, and the counter restarts at 0.
- A mismatch clears the counter; period holds its last value.
REQ-029 Without TRIANGLE_MONITOR_PERIOD_EN, period SHALL be constant 0 and no measurement counter SHALL be present.

Verification
REQ-030 Reset, then feed 0..15,15,14..0,0 continuously: locked=1 after sample 2, peak once after the second 15, valley once after the second 0, mismatch never, err_count=0.
REQ-031 With the macro on, run three full periods: period=32 after the second valley pulse and it stays 32.
REQ-032 Locked mid-up at prev=7, inject 9: mismatch pulses, err_count=1, locked=0; resume with 10,11: relock and direction=0.
REQ-033 Feed 15,15 from ACQ0: locked=1 and direction=1; next 14 is accepted, and 13→12 is accepted.
REQ-034 Drop sample_valid for 5 cycles mid-down: outputs and state are frozen; resume with the next expected value: no mismatch.
REQ-035 Force 300 mismatches: err_count saturates at 255; reset mid-run returns all outputs to 0 on the next edge.

Source files
------------

// File: rtl/triangle_monitor.sv
// Locks onto a 0..TOP,TOP..0,0 bounce-counter stream and flags deviations; all outputs registered, one cycle after the consuming edge.
// No backpressure (sample taken only when sample_valid); define TRIANGLE_MONITOR_PERIOD_EN to enable valley-to-valley period measurement.
module triangle_monitor #(
  parameter int WIDTH = 4
) (
  input  logic             clock,
  input  logic             reset,
  input  logic [WIDTH-1:0] sample,
  input  logic             sample_valid,
  output logic             locked,
  output logic             direction,
  output logic             peak,
  output logic             valley,
  output logic             mismatch,
  output logic [7:0]       err_count,
  output logic [WIDTH+1:0] period
);

  localparam logic [WIDTH-1:0] TOP  = {WIDTH{1'b1}};
  localparam logic [WIDTH-1:0] ZERO = '0;
  localparam logic [WIDTH-1:0] ONE  = WIDTH'(1);

  typedef enum logic [2:0] {
    ACQ0     = 3'd0,
    ACQ1     = 3'd1,
    UP       = 3'd2,
    TOP_HOLD = 3'd3,
    DOWN     = 3'd4,
    BOT_HOLD = 3'd5
  } state_t;

  state_t           state, state_nxt;
  logic [WIDTH-1:0] prev;
  logic [WIDTH-1:0] expected;
  logic             match;
  logic             in_lock;
  logic             locked_nxt, direction_nxt;
  logic             peak_nxt, valley_nxt, mismatch_nxt;

  assign in_lock = (state == UP) || (state == TOP_HOLD) ||
                   (state == DOWN) || (state == BOT_HOLD);

  always_ff @(posedge clock) begin
    if (reset) begin
      state <= ACQ0;
    end else begin
      state <= state_nxt;
    end
  end

  // Endpoint samples go straight to the hold states, so UP never sees prev==TOP and DOWN never sees prev==0.
  always_comb begin
    state_nxt = state;
    expected  = prev;
    case (state)
      UP:       expected = prev + ONE;
      TOP_HOLD: expected = TOP;
      DOWN:     expected = prev - ONE;
      BOT_HOLD: expected = ZERO;
      default:  expected = prev;
    endcase
    match = (sample == expected);
    if (sample_valid) begin
      case (state)
        ACQ0: state_nxt = ACQ1;
        ACQ1: begin
          if ((prev != TOP) && (sample == prev + ONE)) begin
            state_nxt = (sample == TOP) ? TOP_HOLD : UP;
          end else if ((prev != ZERO) && (sample == prev - ONE)) begin
            state_nxt = (sample == ZERO) ? BOT_HOLD : DOWN;
          end else if ((sample == prev) && (prev == TOP)) begin
            state_nxt = DOWN;
          end else if ((sample == prev) && (prev == ZERO)) begin
            state_nxt = UP;
          end else begin
            state_nxt = ACQ1;
          end
        end
        UP: begin
          if (!match)              state_nxt = ACQ1;
          else if (sample == TOP)  state_nxt = TOP_HOLD;
          else                     state_nxt = UP;
        end
        TOP_HOLD: state_nxt = match ? DOWN : ACQ1;
        DOWN: begin
          if (!match)              state_nxt = ACQ1;
          else if (sample == ZERO) state_nxt = BOT_HOLD;
          else                     state_nxt = DOWN;
        end
        BOT_HOLD: state_nxt = match ? UP : ACQ1;
        default:  state_nxt = ACQ0;
      endcase
    end
  end

  always_comb begin
    locked_nxt    = (state_nxt == UP) || (state_nxt == TOP_HOLD) ||
                    (state_nxt == DOWN) || (state_nxt == BOT_HOLD);
    direction_nxt = (state_nxt == TOP_HOLD) || (state_nxt == DOWN);
    peak_nxt      = sample_valid && (state == TOP_HOLD) && match;
    valley_nxt    = sample_valid && (state == BOT_HOLD) && match;
    mismatch_nxt  = sample_valid && in_lock && !match;
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      prev      <= '0;
      locked    <= 1'b0;
      direction <= 1'b0;
      peak      <= 1'b0;
      valley    <= 1'b0;
      mismatch  <= 1'b0;
      err_count <= 8'd0;
    end else begin
      locked    <= locked_nxt;
      direction <= direction_nxt;
      peak      <= peak_nxt;
      valley    <= valley_nxt;
      mismatch  <= mismatch_nxt;
      if (sample_valid) begin
        prev <= sample;
      end
      if (mismatch_nxt && (err_count != 8'hFF)) begin
        err_count <= err_count + 8'd1;
      end
    end
  end

`ifdef TRIANGLE_MONITOR_PERIOD_EN
  logic [WIDTH+1:0] per_cnt;
  logic [WIDTH+1:0] period_q;
  logic             seen_valley;

  // The first valley after locking only arms the measurement; later valleys publish count+1.
  always_ff @(posedge clock) begin
    if (reset) begin
      per_cnt     <= '0;
      period_q    <= '0;
      seen_valley <= 1'b0;
    end else if (sample_valid) begin
      if (mismatch_nxt) begin
        per_cnt     <= '0;
        seen_valley <= 1'b0;
      end else if (in_lock) begin
        if (valley_nxt) begin
          if (seen_valley) begin
            period_q <= per_cnt + 1'b1;
          end
          per_cnt     <= '0;
          seen_valley <= 1'b1;
        end else begin
          per_cnt <= per_cnt + 1'b1;
        end
      end
    end
  end

  assign period = period_q;
`else
  assign period = '0;
`endif

endmodule

// File: tb/tb_triangle_monitor.sv
// Directed table-driven bench for triangle_monitor (WIDTH=4) plus hand-written saturation and reset sequences.
module tb_triangle_monitor;

`ifdef TRIANGLE_MONITOR_PERIOD_EN
  localparam bit PER_EN = 1'b1;
`else
  localparam bit PER_EN = 1'b0;
`endif
  localparam int P32 = PER_EN ? 32 : 0;

  logic       clock;
  logic       reset;
  logic [3:0] sample;
  logic       sample_valid;
  logic       locked, direction, peak, valley, mismatch;
  logic [7:0] err_count;
  logic [5:0] period;

  int n_cmp = 0;
  int n_bad = 0;

  triangle_monitor #(.WIDTH(4)) dut (
    .clock        (clock),
    .reset        (reset),
    .sample       (sample),
    .sample_valid (sample_valid),
    .locked       (locked),
    .direction    (direction),
    .peak         (peak),
    .valley       (valley),
    .mismatch     (mismatch),
    .err_count    (err_count),
    .period       (period)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  typedef struct {
    bit         rst;
    bit         v;
    logic [3:0] s;
    logic       lk, dir, pk, vl, mm;
    logic [7:0] ec;
    logic [5:0] per;
  } vec_t;

  vec_t tbl[$];

  function automatic void add(bit r, bit v, int s, bit lk, bit dir, bit pk, bit vl, bit mm, int ec, int per);
    vec_t e;
    e.rst = r;
    e.v   = v;
    e.s   = 4'(s);
    e.lk  = lk;
    e.dir = dir;
    e.pk  = pk;
    e.vl  = vl;
    e.mm  = mm;
    e.ec  = 8'(ec);
    e.per = 6'(per);
    tbl.push_back(e);
  endfunction

  task automatic check(input string nm, input logic lk, input logic dir, input logic pk, input logic vl,
                       input logic mm, input logic [7:0] ec, input logic [5:0] per);
    logic [18:0] got, want;
    got  = {locked, direction, peak, valley, mismatch, err_count, period};
    want = {lk, dir, pk, vl, mm, ec, per};
    n_cmp++;
    if (got !== want) begin
      n_bad++;
      $display("FAIL %s: got lk=%0b dir=%0b pk=%0b vl=%0b mm=%0b ec=%0d per=%0d, want lk=%0b dir=%0b pk=%0b vl=%0b mm=%0b ec=%0d per=%0d",
               nm, locked, direction, peak, valley, mismatch, err_count, period,
               lk, dir, pk, vl, mm, ec, per);
    end
  endtask

  task automatic step(input logic v, input logic [3:0] s);
    @(negedge clock);
    sample_valid = v;
    sample       = s;
    @(posedge clock);
    #1;
  endtask

  // Reset is asserted together with a valid sample so it must win over sample_valid.
  task automatic do_reset(input string nm);
    @(negedge clock);
    reset        = 1'b1;
    sample_valid = 1'b1;
    sample       = 4'd3;
    @(posedge clock);
    #1;
    check(nm, 0, 0, 0, 0, 0, 8'd0, 6'd0);
    @(negedge clock);
    reset        = 1'b0;
    sample_valid = 1'b0;
  endtask

  initial begin
    int exp_ec;

    // Four passes of the triangle: lock after sample 2, peak on each second 15, valley on each second 0.
    for (int p = 0; p < 4; p++) begin
      for (int i = 0; i < 16; i++)
        add(0, 1, i, !(p == 0 && i == 0), (i == 15), 0, (p > 0 && i == 0), 0, 0, (p >= 2) ? P32 : 0);
      for (int i = 15; i >= 0; i--)
        add(0, 1, i, 1, (i != 0), (i == 15), 0, 0, 0, (p >= 2) ? P32 : 0);
    end
    // Fourth valley, climb to 7, inject 9, relock on 10,11.
    add(0, 1, 0, 1, 0, 0, 1, 0, 0, P32);
    for (int i = 1; i <= 7; i++) add(0, 1, i, 1, 0, 0, 0, 0, 0, P32);
    add(0, 1, 9, 0, 0, 0, 0, 1, 1, P32);
    add(0, 1, 10, 1, 0, 0, 0, 0, 1, P32);
    add(0, 1, 11, 1, 0, 0, 0, 0, 1, P32);
    // Over the top into DOWN, stall five cycles, then resume with the expected value.
    for (int i = 12; i <= 14; i++) add(0, 1, i, 1, 0, 0, 0, 0, 1, P32);
    add(0, 1, 15, 1, 1, 0, 0, 0, 1, P32);
    add(0, 1, 15, 1, 1, 1, 0, 0, 1, P32);
    add(0, 1, 14, 1, 1, 0, 0, 0, 1, P32);
    add(0, 1, 13, 1, 1, 0, 0, 0, 1, P32);
    for (int i = 0; i < 5; i++) add(0, 0, 5, 1, 1, 0, 0, 0, 1, P32);
    add(0, 1, 12, 1, 1, 0, 0, 0, 1, P32);
    add(0, 1, 11, 1, 1, 0, 0, 0, 1, P32);
    // Acquire on the top plateau from reset: 15,15 locks straight into DOWN.
    add(1, 1, 15, 0, 0, 0, 0, 0, 0, 0);
    add(0, 1, 15, 1, 1, 0, 0, 0, 0, 0);
    add(0, 1, 14, 1, 1, 0, 0, 0, 0, 0);
    add(0, 1, 13, 1, 1, 0, 0, 0, 0, 0);
    add(0, 1, 12, 1, 1, 0, 0, 0, 0, 0);

    reset        = 1'b1;
    sample_valid = 1'b1;
    sample       = 4'd5;
    repeat (2) @(posedge clock);
    #1;
    check("reset_state", 0, 0, 0, 0, 0, 8'd0, 6'd0);
    @(negedge clock);
    reset        = 1'b0;
    sample_valid = 1'b0;

    foreach (tbl[i]) begin
      if (tbl[i].rst) do_reset($sformatf("reset_before_vec%0d", i));
      step(tbl[i].v, tbl[i].s);
      check($sformatf("vec%0d_s%0d", i, tbl[i].s), tbl[i].lk, tbl[i].dir, tbl[i].pk,
            tbl[i].vl, tbl[i].mm, tbl[i].ec, tbl[i].per);
    end

    // 300 lock/mismatch rounds: relock on 3 from prev 2, then 2 breaks lock (expected 4).
    do_reset("reset_before_sat");
    step(1, 4'd2);
    check("sat_acq", 0, 0, 0, 0, 0, 8'd0, 6'd0);
    exp_ec = 0;
    for (int k = 1; k <= 300; k++) begin
      step(1, 4'd3);
      check($sformatf("sat_lock%0d", k), 1, 0, 0, 0, 0, 8'(exp_ec), 6'd0);
      step(1, 4'd2);
      if (exp_ec < 255) exp_ec++;
      check($sformatf("sat_mm%0d", k), 0, 0, 0, 0, 1, 8'(exp_ec), 6'd0);
    end
    step(1, 4'd3);
    check("sat_final_lock", 1, 0, 0, 0, 0, 8'd255, 6'd0);
    do_reset("reset_mid_run");
    step(1, 4'd4);
    check("post_reset_acq0", 0, 0, 0, 0, 0, 8'd0, 6'd0);
    step(1, 4'd5);
    check("post_reset_relock", 1, 0, 0, 0, 0, 8'd0, 6'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
